// File: rtl/dequantization.sv
// Dequantizer: (q_in - ZERO_POINT) * M_INV, rounded shift, 32-bit clip.
// Ports: clk, rst, q_in/in_valid/in_ready in, y_out/sat/out_valid/out_ready out.
module dequantization #(
  parameter logic signed [8:0] ZERO_POINT = 9'sd0,
  parameter logic [31:0]       M_INV      = 32'd17883070,
  parameter int                RSHIFT     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  q_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y_out,
  output logic        sat,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [2:0] {
    IDLE, SUB, MUL, RND, SAT, HOLD
  } state_t;

  state_t state, state_nxt;

  logic [8:0]  q_reg;
  logic [9:0]  diff;
  logic [42:0] prod;
  logic [43:0] mag;

  localparam logic [42:0] M_EXT   = {11'd0, M_INV};
  localparam logic [43:0] RND_ADD = (44'd1 << RSHIFT) >> 1;
  localparam logic [43:0] POS_MAX = 44'h0_7FFF_FFFF;
  localparam logic [43:0] NEG_MAX = 44'h0_8000_0000;

  logic [42:0] diff_ext;
  logic [43:0] prod_abs;
  logic [43:0] mag_nxt;
  logic [31:0] y_nxt;
  logic        sat_nxt;

  // Low 43 bits of the product are the same for signed and
  // unsigned multiply, so a plain sign-extended multiply suffices.
  assign diff_ext = {{33{diff[9]}}, diff};
  assign prod_abs = prod[42] ? {1'b0, -prod} : {1'b0, prod};
  assign mag_nxt  = (prod_abs + RND_ADD) >> RSHIFT;

  always_comb begin
    y_nxt   = prod[42] ? (~mag[31:0] + 32'd1) : mag[31:0];
    sat_nxt = 1'b0;
    if (!prod[42] && (mag > POS_MAX)) begin
      y_nxt   = 32'h7FFF_FFFF;
      sat_nxt = 1'b1;
    end else if (prod[42] && (mag > NEG_MAX)) begin
      y_nxt   = 32'h8000_0000;
      sat_nxt = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SUB;
      SUB:     state_nxt = MUL;
      MUL:     state_nxt = RND;
      RND:     state_nxt = SAT;
      SAT:     state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= '0;
      diff  <= '0;
      prod  <= '0;
      mag   <= '0;
      y_out <= '0;
      sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) q_reg <= q_in;
        SUB:  diff  <= {q_reg[8], q_reg}
                     - {ZERO_POINT[8], ZERO_POINT};
        MUL:  prod  <= diff_ext * M_EXT;
        RND:  mag   <= mag_nxt;
        SAT: begin
          y_out <= y_nxt;
          sat   <= sat_nxt;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_dequantization.sv
// Bench for dequantization: three parameter sets run in lockstep
// against an arithmetic model plus hand-computed literal vectors.
module tb_dequantization;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready;
  logic [8:0]  q_in;
  logic [2:0]  rdy, vld, st;
  logic [31:0] yo [3];

  int errors = 0;
  int checks = 0;

  dequantization u0 (
    .clk(clk), .rst(rst), .q_in(q_in), .in_valid(in_valid),
    .in_ready(rdy[0]), .y_out(yo[0]), .sat(st[0]),
    .out_valid(vld[0]), .out_ready(out_ready)
  );

  dequantization #(
    .ZERO_POINT(9'sd0), .M_INV(32'h7FFF_FFFF), .RSHIFT(0)
  ) u1 (
    .clk(clk), .rst(rst), .q_in(q_in), .in_valid(in_valid),
    .in_ready(rdy[1]), .y_out(yo[1]), .sat(st[1]),
    .out_valid(vld[1]), .out_ready(out_ready)
  );

  dequantization #(
    .ZERO_POINT(9'sd10), .M_INV(32'd17883070), .RSHIFT(16)
  ) u2 (
    .clk(clk), .rst(rst), .q_in(q_in), .in_valid(in_valid),
    .in_ready(rdy[2]), .y_out(yo[2]), .sat(st[2]),
    .out_valid(vld[2]), .out_ready(out_ready)
  );

  int     zps [3] = '{0, 0, 10};
  longint mis [3] = '{64'd17883070, 64'd2147483647, 64'd17883070};
  int     rss [3] = '{16, 0, 16};

  function automatic logic [32:0] model(input int q, input int zp,
                                        input longint m, input int rs);
    longint d, p, a, mg, v;
    d  = longint'(q - zp);
    p  = d * m;
    a  = (p < 0) ? -p : p;
    mg = (a + ((64'sd1 <<< rs) >>> 1)) >>> rs;
    v  = (p < 0) ? -mg : mg;
    if (v > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
    if (v < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, v[31:0]};
  endfunction

  function automatic logic [32:0] lit(input logic [31:0] v, input bit s);
    return {s, v};
  endfunction

  task automatic chk(input string name, input logic [32:0] got,
                     input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Transaction-level model: cycles since accept (0 = idle, 5 = holding).
  int          mcnt = 0;
  bit          started = 0;
  logic [8:0]  mq;
  logic [32:0] last [3];

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      mcnt <= 0;
      for (int k = 0; k < 3; k++) last[k] <= '0;
    end else if (mcnt == 0) begin
      if (in_valid) begin
        mq   <= q_in;
        mcnt <= 1;
      end
    end else if (mcnt < 4) begin
      mcnt <= mcnt + 1;
    end else if (mcnt == 4) begin
      mcnt <= 5;
      for (int k = 0; k < 3; k++)
        last[k] <= model(int'($signed(mq)), zps[k], mis[k], rss[k]);
    end else if (out_ready) begin
      mcnt <= 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("in_ready%0d", k), 33'(rdy[k]), 33'(mcnt == 0));
        chk($sformatf("out_valid%0d", k), 33'(vld[k]), 33'(mcnt == 5));
        chk($sformatf("result%0d", k), {st[k], yo[k]}, last[k]);
      end
    end
  end

  task automatic xact(input int q, input bit busy_valid, input int dly,
                      input logic [32:0] e0, input logic [32:0] e1,
                      input logic [32:0] e2, input logic [2:0] msk);
    @(negedge clk);
    in_valid  = 1'b1;
    q_in      = 9'(q);
    out_ready = (dly == 0);
    @(negedge clk);
    in_valid = busy_valid;
    q_in     = 9'($urandom);
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    chk($sformatf("hold_valid_q%0d", q), 33'(vld[0]), 33'd1);
    if (msk[0]) chk($sformatf("lit0_q%0d", q), {st[0], yo[0]}, e0);
    if (msk[1]) chk($sformatf("lit1_q%0d", q), {st[1], yo[1]}, e1);
    if (msk[2]) chk($sformatf("lit2_q%0d", q), {st[2], yo[2]}, e2);
    if (dly > 0) begin
      repeat (dly) @(negedge clk);
      chk($sformatf("stall_y_q%0d", q), {st[0], yo[0]}, e0);
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("idle_ready_q%0d", q), 33'(rdy[0]), 33'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    q_in      = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_y", {st[0], yo[0]}, 33'd0);
    chk("rst_ready", 33'(rdy[0]), 33'd1);
    chk("rst_valid", 33'(vld[0]), 33'd0);

    chk("pin_p1", model(1, 0, 64'd17883070, 16), lit(32'd273, 0));
    chk("pin_m1", model(-1, 0, 64'd17883070, 16), lit(-32'sd273, 0));
    chk("pin_255", model(255, 0, 64'd17883070, 16), lit(32'd69583, 0));
    chk("pin_m256", model(-256, 0, 64'd17883070, 16),
        lit(-32'sd69856, 0));
    chk("pin_satp", model(255, 0, 64'd2147483647, 0),
        lit(32'h7FFF_FFFF, 1));
    chk("pin_satn", model(-256, 0, 64'd2147483647, 0),
        lit(32'h8000_0000, 1));
    chk("pin_zp", model(11, 10, 64'd17883070, 16), lit(32'd273, 0));

    xact(1, 0, 0, lit(32'd273, 0), lit(32'h7FFF_FFFF, 0), '0, 3'b011);
    xact(-1, 0, 0, lit(-32'sd273, 0), lit(32'h8000_0001, 0), '0, 3'b011);
    xact(0, 0, 0, lit(32'd0, 0), lit(32'd0, 0), '0, 3'b011);
    xact(255, 0, 0, lit(32'd69583, 0), lit(32'h7FFF_FFFF, 1), '0, 3'b011);
    xact(-256, 0, 0, lit(-32'sd69856, 0), lit(32'h8000_0000, 1),
         '0, 3'b011);
    xact(1, 0, 10, lit(32'd273, 0), '0, '0, 3'b001);
    xact(11, 1, 0, lit(32'd3002, 0), lit(32'h7FFF_FFFF, 1),
         lit(32'd273, 0), 3'b111);

    @(negedge clk);
    in_valid = 1'b1;
    q_in     = 9'd5;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 33'(rdy[0]), 33'd1);
    chk("abort_valid", 33'(vld[0]), 33'd0);
    chk("abort_y", {st[0], yo[0]}, 33'd0);

    xact(2, 0, 0, lit(32'd546, 0), lit(32'h7FFF_FFFF, 1), '0, 3'b011);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dequantization.md
DEQUANTIZATION -- requirements
Module: dequantization

Interface
REQ-001 SHALL provide parameter ZERO_POINT, default 9'sd0: signed zero point subtracted from the quantized input.
REQ-002 SHALL provide parameter M_INV, default 32'd17883070: unsigned rescale multiplier.
REQ-003 SHALL provide parameter RSHIFT, default 16: right shift applied after multiply, legal range 0..40.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1: sole clock; all state updates on the rising edge.
REQ-006 rst  input  1: synchronous active-high reset.
REQ-007 q_in  input  9: signed quantized value, same width as the quantizer output.
REQ-008 in_valid  input  1: q_in is valid.
REQ-009 in_ready  output  1: block can accept an input.
REQ-010 y_out  output  32: signed dequantized accumulator-domain value.
REQ-011 sat  output  1: y_out was clipped; qualified by out_valid.
REQ-012 out_valid  output  1: y_out and sat are valid.
REQ-013 out_ready  input  1: downstream accepts the result.

Function
REQ-014 SHALL implement the FSM IDLE->SUB->MUL->RND->SAT->HOLD->IDLE, advancing one state per cycle except in IDLE and HOLD.
REQ-015 SHALL assert in_ready only in IDLE; an input is accepted on an edge where in_valid=1 and in_ready=1, capturing q_in and moving to SUB.
REQ-016 SUB SHALL compute diff = q_in - ZERO_POINT as a 10-bit signed value, with no overflow possible.
REQ-017 MUL SHALL compute prod = diff * {1'b0, M_INV} as a 43-bit signed product.
REQ-018 RND SHALL compute mag = (|prod| + (RSHIFT>0 ? 2^(RSHIFT-1) : 0)) >> RSHIFT, giving round-half-away-from-zero that is symmetric about 0.
REQ-019 SAT SHALL reapply the sign of prod to mag; a result above 2^31-1 SHALL give 0x7FFFFFFF, a result below -2^31 SHALL give 0x80000000, and either case SHALL set sat=1; otherwise sat=0.
REQ-020 In HOLD, out_valid=1 and y_out and sat SHALL be held stable until an edge where out_ready=1, then go to IDLE with out_valid=0.
REQ-021 Latency SHALL be exactly 5 rising edges from the accepting edge to out_valid=1 (SUB, MUL, RND, SAT, then HOLD entry).
REQ-022 Maximum throughput SHALL be 1 result per 6 cycles.
REQ-023 No pipelining is permitted: in_ready=0 from the accept edge until the edge that leaves HOLD.
REQ-024 in_valid asserted outside IDLE SHALL be ignored, with no capture and no state change.
REQ-025 q_in changes after the accept edge SHALL NOT affect the in-flight result.
REQ-026 y_out and sat SHALL hold their last values after handshake completion until the next SAT state.
REQ-027 When out_ready=1 on the same cycle HOLD is entered, HOLD SHALL still last at least one cycle so that out_valid is visible.

Reset
REQ-028 When rst=1 at a rising edge, the block SHALL go to IDLE with in_ready=1, out_valid=0, y_out=0, sat=0, and all internal registers cleared.
REQ-029 Reset asserted mid-operation, in any state, SHALL abort the conversion with no output produced.
REQ-030 Reset SHALL take priority over a simultaneous in_valid or out_ready.

Verification
REQ-031 Defaults, q_in=1, out_ready=1 -> out_valid exactly 5 edges after accept, y_out=273, sat=0.
REQ-032 Defaults, q_in=-1 -> y_out=-273; q_in=0 -> y_out=0; q_in=255 -> y_out=69583; q_in=-256 -> y_out=-69856, all with sat=0.
REQ-033 RSHIFT=0, M_INV=32'h7FFFFFFF, q_in=255 -> y_out=0x7FFFFFFF, sat=1; q_in=-256 -> y_out=0x80000000, sat=1.
REQ-034 Defaults, out_ready=0 for 10 cycles after out_valid -> y_out stable at 273 and in_ready=0 throughout; out_ready=1 -> next edge out_valid=0 and in_ready=1.
REQ-035 rst=1 during MUL -> next edge out_valid=0 and in_ready=1; q_in=2 then accepted -> y_out=546.
REQ-036 ZERO_POINT=9'sd10, q_in=11 -> y_out=273; in_valid pulses while busy -> no extra outputs.
